music_rom_player: RTL and testbench



---
 rtl/music_pkg.sv | 47 ++++
 rtl/music_tone_gen.sv | 41 ++++
 rtl/music_rom_player.sv | 143 ++++++++++++++
 tb/tb_music_rom_player.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | music_pkg                                                            |
// | Note-code fields, octave-1 half-period table and player states.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package music_pkg;

   localparam int OCT_MSB = 7;
   localparam int OCT_LSB = 4;
   localparam int DEG_MSB = 3;
   localparam int DEG_LSB = 0;
   localparam logic [7:0] END_CODE = 8'h00;
   localparam int HP_W = 17;

   // Octave-1 half-periods in 50 MHz cycles for C D E F G A B
   localparam logic [HP_W-1:0] BASE [7] = '{
      17'd95554, 17'd85132, 17'd75843, 17'd71586, 17'd63776, 17'd56818, 17'd50619
   };

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LATCH = 3'd2,
      PLAY  = 3'd3,
      GAP   = 3'd4,
      DONE  = 3'd5
   } state_e;

   // Zero means rest: the octave or degree field is out of range
   function automatic logic [HP_W-1:0] half_period(input logic [7:0] code, input int shift);
      logic [3:0]      oct;
      logic [3:0]      deg;
      logic [2:0]      idx;
      logic [HP_W-1:0] base;
      oct = code[OCT_MSB:OCT_LSB];
      deg = code[DEG_MSB:DEG_LSB];
      idx = deg[2:0] - 3'd1;
      base = BASE[idx];
      half_period = '0;
      if (oct >= 4'd1 && oct <= 4'd3 && deg >= 4'd1 && deg <= 4'd7) begin
         half_period = base >> (int'(oct) - 1 + shift);
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/music_tone_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | music_tone_gen                                                       |
// | Square-wave generator: toggles speaker every half_i enabled cycles.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module music_tone_gen
   import music_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            load_i,
   input  logic            en_i,
   input  logic [HP_W-1:0] half_i,
   output logic            speaker_o
);

   logic [HP_W-1:0] cnt_q;
   logic            spk_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         spk_q <= 1'b0;
      end else if (load_i) begin
         cnt_q <= half_i - 1'b1;
         spk_q <= 1'b0;
      end else if (!en_i) begin
         spk_q <= 1'b0;
      end else if (cnt_q == '0) begin
         cnt_q <= half_i - 1'b1;
         spk_q <= ~spk_q;
      end else begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign speaker_o = spk_q;

endmodule
`default_nettype wire

// File: rtl/music_rom_player.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | music_rom_player                                                     |
// | Walks the note ROM and plays each note, then a silent gap.           |
// | Define MUSIC_PLAYER_LOOP_EN to replay the song until stop.           |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module music_rom_player
   import music_pkg::*;
#(
   parameter int ROM_AW     = 9,
   parameter int SONG_LEN   = 37,
   parameter int NOTE_TICKS = 12_500_000,
   parameter int GAP_TICKS  = 1_250_000,
   parameter int TONE_SHIFT = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   output logic [ROM_AW-1:0] address,
   input  logic [7:0]        q,
   output logic              speaker,
   output logic [7:0]        note_code,
   output logic              playing,
   output logic              done
);

   localparam int DUR_W = $clog2(NOTE_TICKS + 1);
   localparam int GAP_W = $clog2(GAP_TICKS + 1);
   localparam logic [DUR_W-1:0]  DUR_LAST  = DUR_W'(NOTE_TICKS - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TICKS - 1);
   localparam logic [ROM_AW-1:0] ADDR_LAST = ROM_AW'(SONG_LEN - 1);

   state_e            state_q;
   logic [ROM_AW-1:0] address_q;
   logic [7:0]        note_code_q;
   logic              playing_q;
   logic              done_q;
   logic [DUR_W-1:0]  dur_q;
   logic [GAP_W-1:0]  gap_q;
   logic [HP_W-1:0]   half_q;
   logic              rest_q;

   logic [HP_W-1:0]   half_d;
   logic              tone_load;
   logic              tone_en;
   logic [HP_W-1:0]   tone_half;

   assign half_d    = half_period(q, TONE_SHIFT);
   assign tone_load = (state_q == LATCH) && !stop && (q != END_CODE);
   assign tone_en   = (state_q == PLAY) && !stop && !rest_q && (dur_q != DUR_LAST);
   assign tone_half = tone_load ? half_d : half_q;

   always_ff @(posedge clock) begin
      if (reset || stop) begin
         state_q     <= IDLE;
         address_q   <= '0;
         note_code_q <= '0;
         playing_q   <= 1'b0;
         done_q      <= 1'b0;
         dur_q       <= '0;
         gap_q       <= '0;
         half_q      <= '0;
         rest_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               address_q <= '0;
               if (start) state_q <= FETCH;
            end
            FETCH: state_q <= LATCH;
            LATCH: begin
               note_code_q <= q;
               if (q == END_CODE) begin
                  state_q   <= DONE;
                  done_q    <= 1'b1;
                  address_q <= '0;
               end else begin
                  half_q    <= half_d;
                  rest_q    <= (half_d == '0);
                  dur_q     <= '0;
                  playing_q <= 1'b1;
                  state_q   <= PLAY;
               end
            end
            PLAY: begin
               if (dur_q == DUR_LAST) begin
                  dur_q   <= '0;
                  gap_q   <= '0;
                  state_q <= GAP;
               end else begin
                  dur_q <= dur_q + 1'b1;
               end
            end
            GAP: begin
               if (gap_q == GAP_LAST) begin
                  gap_q     <= '0;
                  playing_q <= 1'b0;
                  if (address_q == ADDR_LAST) begin
                     state_q     <= DONE;
                     done_q      <= 1'b1;
                     note_code_q <= '0;
                     address_q   <= '0;
                  end else begin
                     address_q <= address_q + 1'b1;
                     state_q   <= FETCH;
                  end
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end
            DONE: begin
               address_q   <= '0;
               note_code_q <= '0;
`ifdef MUSIC_PLAYER_LOOP_EN
               state_q     <= FETCH;
`else
               state_q     <= IDLE;
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   music_tone_gen u_tone (
      .clk_i     (clock),
      .rst_i     (reset),
      .load_i    (tone_load),
      .en_i      (tone_en),
      .half_i    (tone_half),
      .speaker_o (speaker)
   );

   assign address   = address_q;
   assign note_code = note_code_q;
   assign playing   = playing_q;
   assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_music_rom_player.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_music_rom_player                                                  |
// | Self-checking bench: decode table, directed and random songs.        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_music_rom_player;

   localparam int NT_M = 1024;
   localparam int NT_S = 64;
   localparam int GT   = 8;
   localparam int SH   = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_m = 1'b0, stop_m = 1'b0, start_s = 1'b0, stop_s = 1'b0;
   logic [8:0] addr_m, addr_s;
   logic [7:0] q_m, q_s, code_m, code_s;
   logic       spk_m, spk_s, play_m, play_s, done_m, done_s;
   logic [7:0] rom_m [512];
   logic [7:0] rom_s [512];

   int errors = 0;
   int checks = 0;
   logic [19:0] exp_q [$];

   always #5 clk = ~clk;

   always @(posedge clk) q_m <= rom_m[addr_m];
   always @(posedge clk) q_s <= rom_s[addr_s];

   music_rom_player #(.ROM_AW(9), .SONG_LEN(37), .NOTE_TICKS(NT_M), .GAP_TICKS(GT), .TONE_SHIFT(SH)) dut (
      .clock(clk), .reset(rst), .start(start_m), .stop(stop_m), .address(addr_m), .q(q_m),
      .speaker(spk_m), .note_code(code_m), .playing(play_m), .done(done_m));

   music_rom_player #(.ROM_AW(9), .SONG_LEN(4), .NOTE_TICKS(NT_S), .GAP_TICKS(GT), .TONE_SHIFT(SH)) dut_s (
      .clock(clk), .reset(rst), .start(start_s), .stop(stop_s), .address(addr_s), .q(q_s),
      .speaker(spk_s), .note_code(code_s), .playing(play_s), .done(done_s));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [19:0] obs(input bit sel);
      if (sel) return {spk_s, play_s, done_s, code_s, addr_s};
      return {spk_m, play_m, done_m, code_m, addr_m};
   endfunction

   function automatic logic [19:0] rec(input bit s, input bit p, input bit d, input logic [7:0] c, input int a);
      logic [8:0] a9;
      a9 = a[8:0];
      return {s, p, d, c, a9};
   endfunction

   // Half-period straight from the octave/degree rule; 0 means rest
   function automatic int model_half(input logic [7:0] c);
      int base [7];
      int oct;
      int deg;
      base = '{95554, 85132, 75843, 71586, 63776, 56818, 50619};
      oct = int'(c[7:4]);
      deg = int'(c[3:0]);
      if (oct < 1 || oct > 3 || deg < 1 || deg > 7) return 0;
      return base[deg-1] >> (oct - 1 + SH);
   endfunction

   task automatic build_expect(input bit sel, input int max_len);
      int nt, slen, i, half;
      logic [7:0] c, prev;
      bit loop_en;
`ifdef MUSIC_PLAYER_LOOP_EN
      loop_en = 1'b1;
`else
      loop_en = 1'b0;
`endif
      nt = sel ? NT_S : NT_M;
      slen = sel ? 4 : 37;
      exp_q.delete();
      i = 0;
      prev = 8'h00;
      while (exp_q.size() < max_len) begin
         if (i < 0) begin
            exp_q.push_back(rec(0, 0, 0, 8'h00, 0));
         end else begin
            exp_q.push_back(rec(0, 0, 0, prev, i));
            exp_q.push_back(rec(0, 0, 0, prev, i));
            c = sel ? rom_s[i] : rom_m[i];
            if (c == 8'h00) begin
               exp_q.push_back(rec(0, 0, 1, 8'h00, 0));
               prev = 8'h00;
               i = loop_en ? 0 : -1;
            end else begin
               half = model_half(c);
               for (int k = 0; k < nt; k++)
                  exp_q.push_back(rec((half == 0) ? 1'b0 : 1'((k / half) % 2), 1, 0, c, i));
               for (int k = 0; k < GT; k++)
                  exp_q.push_back(rec(0, 1, 0, c, i));
               if (i == slen - 1) begin
                  exp_q.push_back(rec(0, 0, 1, 8'h00, 0));
                  prev = 8'h00;
                  i = loop_en ? 0 : -1;
               end else begin
                  prev = c;
                  i++;
               end
            end
         end
      end
   endtask

   task automatic set_start(input bit sel, input logic v);
      if (sel) start_s = v; else start_m = v;
   endtask

   task automatic set_stop(input bit sel, input logic v);
      if (sel) stop_s = v; else stop_m = v;
   endtask

   // Start, then compare every cycle; stray start pulses mid-note must be ignored
   task automatic run_stream(input bit sel, input string name);
      logic [19:0] e;
      set_start(sel, 1'b1);
      @(negedge clk);
      set_start(sel, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(name, 32'(obs(sel)), 32'(e));
         set_start(sel, (e[18] && $urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
         @(negedge clk);
      end
      set_start(sel, 1'b0);
      set_stop(sel, 1'b1);
      @(negedge clk);
      set_stop(sel, 1'b0);
      check({name, "_stopped"}, 32'(obs(sel)), 32'h0);
   endtask

   typedef struct { logic [7:0] code; int half; } tone_vec_t;

   initial begin
      tone_vec_t tbl [12];
      int first_rise;
      int n;
      int w;
      logic [7:0] c;
      bit seen;

      tbl[0]  = '{8'h13, 296};  tbl[1]  = '{8'h16, 221};
      tbl[2]  = '{8'h21, 186};  tbl[3]  = '{8'h11, 373};
      tbl[4]  = '{8'h22, 166};  tbl[5]  = '{8'h34, 69};
      tbl[6]  = '{8'h35, 62};   tbl[7]  = '{8'h37, 49};
      tbl[8]  = '{8'h48, 0};    tbl[9]  = '{8'h30, 0};
      tbl[10] = '{8'h18, 0};    tbl[11] = '{8'h05, 0};

      for (int i = 0; i < 512; i++) begin
         rom_m[i] = 8'h00;
         rom_s[i] = 8'h00;
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset_main", 32'(obs(0)), 32'h0);
      check("reset_short", 32'(obs(1)), 32'h0);

      // Start-to-PLAY latency
      rom_m[0] = 8'h13;
      rom_m[1] = 8'h00;
      start_m = 1'b1;
      @(negedge clk);
      start_m = 1'b0;
      check("fetch_state", 32'(obs(0)), 32'h0);
      @(negedge clk);
      check("latch_playing", 32'(play_m), 32'h0);
      @(negedge clk);
      check("play_playing", 32'(play_m), 32'h1);
      check("play_code", 32'(code_m), 32'h13);
      stop_m = 1'b1;
      @(negedge clk);
      stop_m = 1'b0;

      // Decode table: first speaker rise lands exactly one half-period into PLAY
      for (int t = 0; t < 12; t++) begin
         rom_m[0] = tbl[t].code;
         rom_m[1] = 8'h00;
         start_m = 1'b1;
         @(negedge clk);
         start_m = 1'b0;
         @(negedge clk);
         @(negedge clk);
         check("tbl_playing", 32'(play_m), 32'h1);
         first_rise = -1;
         for (int k = 0; k < NT_M && first_rise < 0; k++) begin
            if (spk_m) first_rise = k;
            @(negedge clk);
         end
         check($sformatf("tbl_half_%h", tbl[t].code), 32'(first_rise),
               32'((tbl[t].half == 0) ? -1 : tbl[t].half));
         stop_m = 1'b1;
         @(negedge clk);
         stop_m = 1'b0;
      end

      // Three notes then end marker
      rom_m[0] = 8'h13; rom_m[1] = 8'h16; rom_m[2] = 8'h21; rom_m[3] = 8'h00;
      build_expect(0, 3 * (NT_M + GT + 2) + 12);
      run_stream(0, "song_endmark");

      // Random songs
      for (int s = 0; s < 3; s++) begin
         n = $urandom_range(1, 3);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) < 7)
               c = {4'($urandom_range(1, 3)), 4'($urandom_range(1, 7))};
            else
               c = 8'($urandom_range(1, 255));
            rom_m[i] = c;
         end
         rom_m[n] = 8'h00;
         build_expect(0, n * (NT_M + GT + 2) + 12);
         run_stream(0, $sformatf("song_rand%0d", s));
      end

      // Stop mid-PLAY of address 5, then restart
      for (int i = 0; i < 8; i++) rom_m[i] = {4'($urandom_range(1, 3)), 4'($urandom_range(1, 7))};
      rom_m[8] = 8'h00;
      start_m = 1'b1;
      @(negedge clk);
      start_m = 1'b0;
      w = 0;
      while (!(addr_m == 9'd5 && play_m) && w < 8000) begin
         @(negedge clk);
         w++;
      end
      check("reach_addr5", 32'(addr_m == 9'd5 && play_m), 32'h1);
      repeat (10) @(negedge clk);
      stop_m = 1'b1;
      @(negedge clk);
      stop_m = 1'b0;
      check("stop_outputs", 32'({spk_m, play_m, done_m, addr_m}), 32'h0);
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (done_m || play_m) seen = 1'b1;
         @(negedge clk);
      end
      check("stop_no_done", 32'(seen), 32'h0);
      start_m = 1'b1;
      stop_m = 1'b1;
      @(negedge clk);
      start_m = 1'b0;
      stop_m = 1'b0;
      repeat (3) @(negedge clk);
      check("stop_beats_start", 32'({play_m, addr_m}), 32'h0);
      start_m = 1'b1;
      @(negedge clk);
      start_m = 1'b0;
      check("restart_addr", 32'(addr_m), 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("restart_play", 32'({play_m, code_m, addr_m}), 32'({1'b1, rom_m[0], 9'd0}));

      // Reset mid-note
      repeat (50) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("reset_midnote", 32'(obs(0)), 32'h0);
      repeat (3) @(negedge clk);
      check("reset_idle", 32'(obs(0)), 32'h0);

      // Length-terminated song (loops when the replay feature is built in)
      rom_s[0] = 8'h13; rom_s[1] = 8'h48; rom_s[2] = 8'h16; rom_s[3] = 8'h21;
      build_expect(1, 2 * (4 * (NT_S + GT + 2) + 1) + 10);
      run_stream(1, "song_short");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
